// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler:
// hold-vector encodings, controller state codes and default widths.
package pipe_ctrl_pkg;

   localparam int CNT_W_DEF  = 5;
   localparam int ADDR_W_DEF = 32;

   // Hold vector bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
   // A stage held while the next stage runs makes the downstream register load a NOP.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_MC_BUSY    = 2'd1,
      ST_FLUSH_PEND = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Countdown for multi-cycle EX operations. Loads the remaining stall count,
// decrements when enabled and saturates at zero so it can never wrap.
module mc_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_is_one
);

   logic [CNT_W-1:0] r_cnt;

   // Load has priority over decrement; decrement stops at zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Outputs are combinational from the inputs and the controller state.
// A branch resolved while data memory is busy is parked and replayed when memory frees up.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stallreq_if,
   input  logic              i_stallreq_id,
   input  logic              i_stallreq_mem,
   input  logic              i_ex_mc_start,
   input  logic [CNT_W-1:0]  i_ex_mc_len,
   input  logic              i_ex_branch,
   input  logic [ADDR_W-1:0] i_ex_target,
   output logic [5:0]        o_stall,
   output logic              o_flush,
   output logic [ADDR_W-1:0] o_new_pc,
   output logic              o_mc_last,
   output logic [1:0]        o_state
);

   ctrl_state_e       r_state;
   logic [ADDR_W-1:0] r_pend_pc;

   ctrl_state_e       w_next_state;
   logic [ADDR_W-1:0] w_pend_pc_nxt;
   logic              w_cnt_load;
   logic              w_cnt_dec;
   logic [CNT_W-1:0]  w_cnt_load_val;
   logic              w_cnt_is_one;

   // The start cycle is itself a stall cycle, so the countdown holds len-1.
   assign w_cnt_load_val = i_ex_mc_len - CNT_W'(1);

   mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_cnt_dec),
      .o_is_one   (w_cnt_is_one)
   );

   // Priority mux for the hold vector, flush/redirect and next-state selection.
   always_comb begin
      o_stall       = STALL_NONE;
      o_flush       = NO_STOP;
      o_new_pc      = '0;
      o_mc_last     = 1'b0;
      w_next_state  = r_state;
      w_pend_pc_nxt = r_pend_pc;
      w_cnt_load    = 1'b0;
      w_cnt_dec     = 1'b0;
      if (!i_rst) begin
         case (r_state)
            ST_RUN: begin
               if (i_ex_branch) begin
                  // Branch beats a simultaneous mc_start; a flush drops id/if requests.
                  if (i_stallreq_mem) begin
                     o_stall       = STALL_MEM;
                     w_pend_pc_nxt = i_ex_target;
                     w_next_state  = ST_FLUSH_PEND;
                  end else begin
                     o_flush  = STOP;
                     o_new_pc = i_ex_target;
                  end
               end else begin
                  if (i_ex_mc_start && (i_ex_mc_len != '0)) begin
                     o_stall = STALL_EX;
                     if (i_ex_mc_len == CNT_W'(1)) begin
                        o_mc_last = 1'b1;
                     end else begin
                        w_cnt_load   = 1'b1;
                        w_next_state = ST_MC_BUSY;
                     end
                  end else if (i_stallreq_id) begin
                     o_stall = STALL_ID;
                  end else if (i_stallreq_if) begin
                     o_stall = STALL_IF;
                  end
                  if (i_stallreq_mem) begin
                     o_stall = STALL_MEM;
                  end
               end
            end
            ST_MC_BUSY: begin
               // EX is frozen: branch and mc_start inputs are not looked at here.
               if (i_stallreq_mem) begin
                  o_stall = STALL_MEM;
               end else begin
                  o_stall   = STALL_EX;
                  w_cnt_dec = 1'b1;
                  if (w_cnt_is_one) begin
                     o_mc_last    = 1'b1;
                     w_next_state = ST_RUN;
                  end
               end
            end
            ST_FLUSH_PEND: begin
               if (i_stallreq_mem) begin
                  o_stall = STALL_MEM;
               end else begin
                  o_flush      = STOP;
                  o_new_pc     = r_pend_pc;
                  w_next_state = ST_RUN;
               end
            end
            default: begin
               w_next_state = ST_RUN;
            end
         endcase
      end
   end

   // Controller state and parked branch target; reset discards any pending work.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_RUN;
         r_pend_pc <= '0;
      end else begin
         r_state   <= w_next_state;
         r_pend_pc <= w_pend_pc_nxt;
      end
   end

   assign o_state = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven bench for pipe_ctrl: one table row per clock cycle with
// hand-computed outputs, plus hand-written reset-in-flight sequences.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        sreq_if;
   logic        sreq_id;
   logic        sreq_mem;
   logic        mc_start;
   logic [4:0]  mc_len;
   logic        branch;
   logic [31:0] target;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_last;
   logic [1:0]  state;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic        rst;
      logic        sif;
      logic        sid;
      logic        smem;
      logic        mcs;
      logic [4:0]  len;
      logic        br;
      logic [31:0] tgt;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      logic        e_last;
      logic [1:0]  e_state;
   } vec_t;

   vec_t tbl[$];

   pipe_ctrl #(.CNT_W(5), .ADDR_W(32)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_stallreq_if  (sreq_if),
      .i_stallreq_id  (sreq_id),
      .i_stallreq_mem (sreq_mem),
      .i_ex_mc_start  (mc_start),
      .i_ex_mc_len    (mc_len),
      .i_ex_branch    (branch),
      .i_ex_target    (target),
      .o_stall        (stall),
      .o_flush        (flush),
      .o_new_pc       (new_pc),
      .o_mc_last      (mc_last),
      .o_state        (state)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic r, input logic sif, input logic sid, input logic smem,
                      input logic mcs, input logic [4:0] len, input logic br,
                      input logic [31:0] tgt, input logic [5:0] es, input logic ef,
                      input logic [31:0] ep, input logic el, input logic [1:0] est);
      vec_t v;
      v.rst = r; v.sif = sif; v.sid = sid; v.smem = smem; v.mcs = mcs; v.len = len;
      v.br = br; v.tgt = tgt; v.e_stall = es; v.e_flush = ef; v.e_pc = ep;
      v.e_last = el; v.e_state = est;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, input logic sif, input logic sid, input logic smem,
                        input logic mcs, input logic [4:0] len, input logic br,
                        input logic [31:0] tgt);
      rst = r; sreq_if = sif; sreq_id = sid; sreq_mem = smem;
      mc_start = mcs; mc_len = len; branch = br; target = tgt;
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic build_table();
      // test 1: reset with every request high, then idle
      add(1,1,1,1,1,5'd4,1,32'h55,  STALL_NONE,0,0,0,ST_RUN);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      // test 2: id beats if, then if alone
      add(0,1,1,0,0,5'd0,0,0,       STALL_ID,0,0,0,ST_RUN);
      add(0,1,0,0,0,5'd0,0,0,       STALL_IF,0,0,0,ST_RUN);
      // test 3: len=4 op, four stalled cycles, mc_last on the 4th
      add(0,0,0,0,1,5'd4,0,0,       STALL_EX,0,0,0,ST_RUN);
      add(0,0,0,0,0,5'd0,0,0,       STALL_EX,0,0,0,ST_MC_BUSY);
      add(0,0,0,0,0,5'd0,0,0,       STALL_EX,0,0,0,ST_MC_BUSY);
      add(0,0,0,0,0,5'd0,0,0,       STALL_EX,0,0,1,ST_MC_BUSY);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      // test 3 rerun: two mem cycles mid-op stretch it to six
      add(0,0,0,0,1,5'd4,0,0,       STALL_EX,0,0,0,ST_RUN);
      add(0,0,0,0,0,5'd0,0,0,       STALL_EX,0,0,0,ST_MC_BUSY);
      add(0,0,0,1,0,5'd0,0,0,       STALL_MEM,0,0,0,ST_MC_BUSY);
      add(0,0,0,1,0,5'd0,0,0,       STALL_MEM,0,0,0,ST_MC_BUSY);
      add(0,0,0,0,0,5'd0,0,0,       STALL_EX,0,0,0,ST_MC_BUSY);
      add(0,0,0,0,0,5'd0,0,0,       STALL_EX,0,0,1,ST_MC_BUSY);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      // len=1: single stall with mc_last; len=0: ignored
      add(0,0,0,0,1,5'd1,0,0,       STALL_EX,0,0,1,ST_RUN);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      add(0,0,0,0,1,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      // test 4: branch with id request, flush wins
      add(0,0,1,0,0,5'd0,1,32'h100, STALL_NONE,1,32'h100,0,ST_RUN);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      // branch and mc_start together: branch wins, op discarded
      add(0,0,0,0,1,5'd3,1,32'h300, STALL_NONE,1,32'h300,0,ST_RUN);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      // test 5: branch during 3-cycle mem stall, replayed on 4th cycle
      add(0,0,0,1,0,5'd0,1,32'h200, STALL_MEM,0,0,0,ST_RUN);
      add(0,0,0,1,0,5'd0,0,0,       STALL_MEM,0,0,0,ST_FLUSH_PEND);
      add(0,0,0,1,0,5'd0,0,0,       STALL_MEM,0,0,0,ST_FLUSH_PEND);
      add(0,1,1,0,0,5'd0,0,0,       STALL_NONE,1,32'h200,0,ST_FLUSH_PEND);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
      // branch while MC_BUSY is ignored
      add(0,0,0,0,1,5'd2,0,0,       STALL_EX,0,0,0,ST_RUN);
      add(0,0,0,0,0,5'd0,1,32'h400, STALL_EX,0,0,1,ST_MC_BUSY);
      add(0,0,0,0,0,5'd0,0,0,       STALL_NONE,0,0,0,ST_RUN);
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         drive(0,0,0,0,0,5'd0,0,0);
         @(negedge clk);
         chk({tag, "_stall"},   k, {26'd0, stall},   {26'd0, STALL_NONE});
         chk({tag, "_flush"},   k, {31'd0, flush},   32'd0);
         chk({tag, "_mc_last"}, k, {31'd0, mc_last}, 32'd0);
         chk({tag, "_state"},   k, {30'd0, state},   {30'd0, ST_RUN});
         next_cycle();
      end
   endtask

   initial begin
      drive(1,0,0,0,0,5'd0,0,0);
      next_cycle();
      build_table();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].sif, tbl[i].sid, tbl[i].smem,
               tbl[i].mcs, tbl[i].len, tbl[i].br, tbl[i].tgt);
         @(negedge clk);
         chk("stall",   i, {26'd0, stall},   {26'd0, tbl[i].e_stall});
         chk("flush",   i, {31'd0, flush},   {31'd0, tbl[i].e_flush});
         chk("mc_last", i, {31'd0, mc_last}, {31'd0, tbl[i].e_last});
         chk("state",   i, {30'd0, state},   {30'd0, tbl[i].e_state});
         if (tbl[i].e_flush) chk("new_pc", i, new_pc, tbl[i].e_pc);
         next_cycle();
      end

      // reset in cycle 2 of a len=5 op
      drive(0,0,0,0,1,5'd5,0,0);
      @(negedge clk);
      chk("rstmc_start", 0, {26'd0, stall}, {26'd0, STALL_EX});
      next_cycle();
      drive(1,0,0,0,0,5'd0,0,0);
      @(negedge clk);
      chk("rstmc_rst_stall", 0, {26'd0, stall}, {26'd0, STALL_NONE});
      chk("rstmc_rst_last",  0, {31'd0, mc_last}, 32'd0);
      next_cycle();
      check_idle("rstmc", 6);

      // reset while a branch is parked in FLUSH_PEND
      drive(0,0,0,1,0,5'd0,1,32'h800);
      @(negedge clk);
      chk("rstfp_br", 0, {26'd0, stall}, {26'd0, STALL_MEM});
      next_cycle();
      drive(0,0,0,1,0,5'd0,0,0);
      @(negedge clk);
      chk("rstfp_pend", 0, {30'd0, state}, {30'd0, ST_FLUSH_PEND});
      next_cycle();
      drive(1,0,0,0,0,5'd0,0,0);
      @(negedge clk);
      chk("rstfp_rst_flush", 0, {31'd0, flush}, 32'd0);
      next_cycle();
      check_idle("rstfp", 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
